fp_mul_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754 multiplier; successor to the single-cycle FP multiply.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_mul_round.sv | 58 +++++
 rtl/fp_mul_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the pipelined floating-point multiplier.
//   - bias()      : exponent bias for a given exponent field width
//   - FLAG_*      : bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag word
//   - canon_nan() : canonical quiet NaN pattern for a given format
//   - fp_class_t  : operand classification used by the unpack stage
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    localparam int FLAG_NX  = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_INV = 3;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned wide; callers slice the low 1+exp_w+man_w bits.
    // Pattern is {0, all-ones exponent, fraction MSB set}.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// fp_mul_round
// Combinational round-and-pack for the multiplier's last stage.
// It rounds a normalised fraction to nearest-even and detects exponent overflow/underflow.
// It then packs the IEEE-754 result and its flag word.
// Ports:
//   sign    in   1          result sign
//   esum    in   EXP_W+2    biased exponent before rounding, signed
//   frac    in   MAN_W      normalised fraction (hidden bit removed)
//   guard   in   1          first bit below the fraction LSB
//   sticky  in   1          OR of every bit below guard
//   data    out  1+EXP_W+MAN_W  packed result
//   flags   out  4          {invalid, overflow, underflow, inexact}
module fp_mul_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  esum,
    input  logic [MAN_W-1:0]         frac,
    input  logic                     guard,
    input  logic                     sticky,
    output logic [EXP_W+MAN_W:0]     data,
    output logic [3:0]               flags
);
    import fp_pkg::*;

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    logic                  round_up;
    logic [MAN_W:0]        frac_sum;
    logic signed [EW-1:0]  esum_r;

    always_comb begin
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        // A carry out means the fraction wrapped to zero and the value doubled.
        esum_r   = esum + $signed({{(EW-1){1'b0}}, frac_sum[MAN_W]});

        data  = '0;
        flags = '0;
        if (esum_r >= EXP_MAX) begin
            data            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLAG_OVF] = 1'b1;
            flags[FLAG_NX]  = 1'b1;
        end else if (esum_r <= EXP_ZERO) begin
            // Only finite nonzero operands reach this path, so the flushed value is always inexact.
            data            = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            flags[FLAG_UNF] = 1'b1;
            flags[FLAG_NX]  = 1'b1;
        end else begin
            data           = {sign, esum_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
            flags[FLAG_NX] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe
// This is a three-stage pipelined IEEE-754 multiplier, parametrised on format.
// Stage 1 unpacks, classifies and multiplies. Stage 2 normalises. Stage 3 rounds and packs.
// The whole pipe advances together whenever the output register is empty or being drained.
// Ports:
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              operand pair valid
//   in_ready   out  1              operands accepted this cycle
//   in_a/in_b  in   1+EXP_W+MAN_W  operands {sign, exp, frac}
//   in_tag     in   TAG_W          sideband tag
//   out_valid  out  1              result valid
//   out_ready  in   1              consumer accepts result
//   out_data   out  1+EXP_W+MAN_W  product
//   out_tag    out  TAG_W          tag of out_data
//   out_flags  out  4              {invalid, overflow, underflow, inexact}
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);
    import fp_pkg::*;

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(bias(EXP_W));
    localparam logic [63:0]          NAN_FULL = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         NAN_VAL  = NAN_FULL[W-1:0];

    function automatic fp_class_t classify(input logic [W-1:0] x);
        if (x[W-2:MAN_W] == '0) return ZERO;
        if (x[W-2:MAN_W] == '1) begin
            if (x[MAN_W-1:0] == '0) return INF;
            if (x[MAN_W-1])         return QNAN;
            return SNAN;
        end
        return NORM;
    endfunction

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1 combinational: classify, exponent sum, significand product, special override.
    fp_class_t             cls_a, cls_b;
    logic                  nan_any, snan_any, inf_any, zero_any, inf_zero;
    logic                  s1_sign_d;
    logic signed [EW-1:0]  s1_esum_d;
    logic [PW-1:0]         s1_prod_d;
    logic                  s1_special_d;
    logic [W-1:0]          s1_spec_data_d;
    logic [3:0]            s1_spec_flags_d;

    always_comb begin
        cls_a     = classify(in_a);
        cls_b     = classify(in_b);
        nan_any   = (cls_a == QNAN) || (cls_a == SNAN) || (cls_b == QNAN) || (cls_b == SNAN);
        snan_any  = (cls_a == SNAN) || (cls_b == SNAN);
        inf_any   = (cls_a == INF) || (cls_b == INF);
        zero_any  = (cls_a == ZERO) || (cls_b == ZERO);
        inf_zero  = inf_any && zero_any;

        s1_sign_d = in_a[W-1] ^ in_b[W-1];
        s1_esum_d = $signed({2'b00, in_a[W-2:MAN_W]}) + $signed({2'b00, in_b[W-2:MAN_W]}) - BIAS_S;
        s1_prod_d = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});

        s1_special_d    = 1'b0;
        s1_spec_data_d  = '0;
        s1_spec_flags_d = '0;
        if (nan_any || inf_zero) begin
            s1_special_d              = 1'b1;
            s1_spec_data_d            = NAN_VAL;
            s1_spec_flags_d[FLAG_INV] = snan_any | inf_zero;
        end else if (inf_any) begin
            s1_special_d   = 1'b1;
            s1_spec_data_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_any) begin
            s1_special_d   = 1'b1;
            s1_spec_data_d = {s1_sign_d, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end
    end

    logic                  s1_valid, s1_sign, s1_special;
    logic signed [EW-1:0]  s1_esum;
    logic [PW-1:0]         s1_prod;
    logic [W-1:0]          s1_spec_data;
    logic [3:0]            s1_spec_flags;
    logic [TAG_W-1:0]      s1_tag;

    // Stage 2 combinational: the product lies in [1,4), so at most one position of normalisation is needed.
    logic signed [EW-1:0]  norm_esum;
    logic [MAN_W-1:0]      norm_frac;
    logic                  norm_guard, norm_sticky;

    always_comb begin
        if (s1_prod[PW-1]) begin
            norm_esum   = s1_esum + EW'(1);
            norm_frac   = s1_prod[2*MAN_W:MAN_W+1];
            norm_guard  = s1_prod[MAN_W];
            norm_sticky = |s1_prod[MAN_W-1:0];
        end else begin
            norm_esum   = s1_esum;
            norm_frac   = s1_prod[2*MAN_W-1:MAN_W];
            norm_guard  = s1_prod[MAN_W-1];
            norm_sticky = |s1_prod[MAN_W-2:0];
        end
    end

    logic                  s2_valid, s2_sign, s2_special, s2_guard, s2_sticky;
    logic signed [EW-1:0]  s2_esum;
    logic [MAN_W-1:0]      s2_frac;
    logic [W-1:0]          s2_spec_data;
    logic [3:0]            s2_spec_flags;
    logic [TAG_W-1:0]      s2_tag;

    logic [W-1:0]          rnd_data;
    logic [3:0]            rnd_flags;

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign   (s2_sign),
        .esum   (s2_esum),
        .frac   (s2_frac),
        .guard  (s2_guard),
        .sticky (s2_sticky),
        .data   (rnd_data),
        .flags  (rnd_flags)
    );

    // All three stages share one enable, so a stalled output freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_esum       <= '0;
            s1_prod       <= '0;
            s1_special    <= 1'b0;
            s1_spec_data  <= '0;
            s1_spec_flags <= '0;
            s1_tag        <= '0;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_esum       <= '0;
            s2_frac       <= '0;
            s2_guard      <= 1'b0;
            s2_sticky     <= 1'b0;
            s2_special    <= 1'b0;
            s2_spec_data  <= '0;
            s2_spec_flags <= '0;
            s2_tag        <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_tag       <= '0;
            out_flags     <= '0;
        end else if (adv) begin
            s1_valid      <= in_valid;
            s1_sign       <= s1_sign_d;
            s1_esum       <= s1_esum_d;
            s1_prod       <= s1_prod_d;
            s1_special    <= s1_special_d;
            s1_spec_data  <= s1_spec_data_d;
            s1_spec_flags <= s1_spec_flags_d;
            s1_tag        <= in_tag;
            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_esum       <= norm_esum;
            s2_frac       <= norm_frac;
            s2_guard      <= norm_guard;
            s2_sticky     <= norm_sticky;
            s2_special    <= s1_special;
            s2_spec_data  <= s1_spec_data;
            s2_spec_flags <= s1_spec_flags;
            s2_tag        <= s1_tag;
            out_valid     <= s2_valid;
            out_data      <= s2_special ? s2_spec_data  : rnd_data;
            out_flags     <= s2_special ? s2_spec_flags : rnd_flags;
            out_tag       <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe
// Directed bench for fp_mul_pipe: an FP32 instance and an FP16 instance share clock and reset.
// Expected results are hand-computed IEEE-754 products.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_data;
    logic [3:0]  in_tag, out_tag, out_flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_data;
    logic [3:0]  h_in_tag, h_out_tag, h_out_flags;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .in_a      (h_in_a),
        .in_b      (h_in_b),
        .in_tag    (h_in_tag),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .out_data  (h_out_data),
        .out_tag   (h_out_tag),
        .out_flags (h_out_flags)
    );

    int checks = 0;
    int passes = 0;

    // Stream operands 1.0 .. 8.0, each multiplied by 2.0.
    logic [31:0] stream_a   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] stream_exp [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                    32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, expv);
    endtask

    // Presents one operand pair for exactly one clock edge.
    task automatic applyStimulus(input bit half, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag);
        @(negedge clk);
        if (half) begin
            h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_tag = tag; h_in_valid = 1'b1;
        end else begin
            in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        h_in_valid = 1'b0;
    endtask

    // The result must be absent after one and two edges, then present after the third.
    task automatic checkOutput(input string name, input bit half, input logic [31:0] exp_data,
                               input logic [3:0] exp_flags, input logic [3:0] exp_tag);
        logic        v;
        logic [31:0] d;
        logic [3:0]  f, t;
        #1;
        v = half ? h_out_valid : out_valid;
        check({name, "_lat1"}, 32'(v), 32'd0);
        @(negedge clk); #1;
        v = half ? h_out_valid : out_valid;
        check({name, "_lat2"}, 32'(v), 32'd0);
        @(negedge clk); #1;
        if (half) begin
            v = h_out_valid; d = 32'(h_out_data); f = h_out_flags; t = h_out_tag;
        end else begin
            v = out_valid; d = out_data; f = out_flags; t = out_tag;
        end
        check({name, "_valid"}, 32'(v), 32'd1);
        check({name, "_data"},  d, exp_data);
        check({name, "_flags"}, 32'(f), 32'(exp_flags));
        check({name, "_tag"},   32'(t), 32'(exp_tag));
    endtask

    int          sent, recv;
    logic [31:0] held;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_tag = '0; h_out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_tag",   32'(out_tag), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_h_valid",   32'(h_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 * 2.0 = 3.0
        applyStimulus(0, 32'h3FC00000, 32'h40000000, 4'd3);
        checkOutput("basic", 0, 32'h40400000, 4'b0000, 4'd3);
        // (1+2^-23)^2: the 2^-46 term is only sticky, so truncation and inexact
        applyStimulus(0, 32'h3F800001, 32'h3F800001, 4'd5);
        checkOutput("sq_ulp", 0, 32'h3F800002, 4'b0001, 4'd5);
        // exact halfway, odd LSB -> rounds up to even
        applyStimulus(0, 32'h3F800001, 32'h3FC00000, 4'd6);
        checkOutput("tie_up", 0, 32'h3FC00002, 4'b0001, 4'd6);
        // exact halfway, even LSB -> stays
        applyStimulus(0, 32'h3F800003, 32'h3FC00000, 4'd7);
        checkOutput("tie_even", 0, 32'h3FC00004, 4'b0001, 4'd7);
        // 2 - 2^-45 rounds up through a fraction carry to exactly 2.0
        applyStimulus(0, 32'h3FFFFFFE, 32'h3F800001, 4'd8);
        checkOutput("carry", 0, 32'h40000000, 4'b0001, 4'd8);
        // -1.5 * 2.0 = -3.0
        applyStimulus(0, 32'hBFC00000, 32'h40000000, 4'd9);
        checkOutput("neg", 0, 32'hC0400000, 4'b0000, 4'd9);
        // 2^127 * 2^127 overflows
        applyStimulus(0, 32'h7F000000, 32'h7F000000, 4'd10);
        checkOutput("ovf", 0, 32'h7F800000, 4'b0101, 4'd10);
        // 2^-126 * 0.5 underflows to zero
        applyStimulus(0, 32'h00800000, 32'h3F000000, 4'd11);
        checkOutput("unf", 0, 32'h00000000, 4'b0011, 4'd11);
        applyStimulus(0, 32'h7F800000, 32'h00000000, 4'd12);
        checkOutput("inf_zero", 0, 32'h7FC00000, 4'b1000, 4'd12);
        applyStimulus(0, 32'hFF800000, 32'h40000000, 4'd13);
        checkOutput("neg_inf", 0, 32'hFF800000, 4'b0000, 4'd13);
        applyStimulus(0, 32'h7F800001, 32'h3F800000, 4'd14);
        checkOutput("snan", 0, 32'h7FC00000, 4'b1000, 4'd14);
        applyStimulus(0, 32'h7FC00000, 32'h3F800000, 4'd15);
        checkOutput("qnan", 0, 32'h7FC00000, 4'b0000, 4'd15);
        applyStimulus(0, 32'h80000000, 32'h40400000, 4'd1);
        checkOutput("neg_zero", 0, 32'h80000000, 4'b0000, 4'd1);
        // denormal input is flushed to zero without flags
        applyStimulus(0, 32'h00000001, 32'h40000000, 4'd2);
        checkOutput("denorm", 0, 32'h00000000, 4'b0000, 4'd2);

        // FP16: 1.5 * 2.0 = 3.0, and 65504 * 2 overflows
        applyStimulus(1, 32'h00003E00, 32'h00004000, 4'd4);
        checkOutput("h_basic", 1, 32'h00004200, 4'b0000, 4'd4);
        applyStimulus(1, 32'h00007BFF, 32'h00004000, 4'd5);
        checkOutput("h_ovf", 1, 32'h00007C00, 4'b0101, 4'd5);

        // Back-to-back stream of 8, with the consumer stalled for cycles 8..12.
        sent = 0;
        recv = 0;
        held = '0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 8 && c < 13);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a   = stream_a[sent];
                in_b   = 32'h40000000;
                in_tag = 4'(sent + 1);
            end
            #1;
            if (c >= 8 && c < 13) begin
                check("hold_in_ready", 32'(in_ready), 32'd0);
                if (c == 8) held = out_data;
                else        check("hold_data", out_data, held);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("stream_data", out_data, stream_exp[recv]);
                check("stream_tag",  32'(out_tag), 32'(recv + 1));
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'd8);
        @(negedge clk); #1;
        check("stream_drain", 32'(out_valid), 32'd0);

        // Reset in the middle of a stream discards everything in flight.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = stream_a[c];
            in_b     = 32'h40000000;
            in_tag   = 4'(c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_data",  out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("post_reset_idle", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
